// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the stream arbiters.
// Holds the index-width rule and the lock FSM encoding.
package arbiter_pkg;

  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

endpackage

// File: rtl/arbitration_logic_rr.sv
// Round-robin one-hot grant from a request vector and start pointer.
// Wrap-around comes free from searching a doubled request vector.
module arbitration_logic_rr
  import arbiter_pkg::*;
#(
  parameter int N   = 2,
  parameter int IDW = idw(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant
);

  localparam logic [2*N-1:0] ONE = (2*N)'(1);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] mask;
  logic [2*N-1:0] masked;
  logic [2*N-1:0] first;

  // Mask off bits below ptr, isolate lowest set bit, fold halves.
  always_comb begin
    dbl    = {req, req};
    mask   = ~((ONE << ptr) - ONE);
    masked = dbl & mask;
    first  = masked & (~masked + ONE);
    grant  = first[N-1:0] | first[2*N-1:N];
  end

endmodule

// File: rtl/arbiter_rr_locked.sv
// Round-robin stream arbiter with packet locking and registered output.
// A winner keeps the port until its last beat when LOCK is set.
module arbiter_rr_locked
  import arbiter_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int N      = 2,
  parameter int LOCK   = 1,
  parameter int IDW    = idw(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid [N-1:0],
  input  logic [DWIDTH-1:0] in_data  [N-1:0],
  input  logic              in_last  [N-1:0],
  output logic              in_ready [N-1:0],
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last,
  output logic [IDW-1:0]    out_src,
  input  logic              out_ready
);

  arb_state_t state;
  arb_state_t state_nx;

  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    lock_id;
  logic [IDW-1:0]    sel;
  logic [IDW-1:0]    ptr_nx;
  logic [N-1:0]      req;
  logic [N-1:0]      rr_grant;
  logic [N-1:0]      grant;
  logic              load_en;
  logic              xfer;
  logic              sel_last;
  logic [DWIDTH-1:0] sel_data;

  // Flatten per-requester valids for the grant search.
  always_comb begin
    req = '0;
    for (int i = 0; i < N; i++) begin
      req[i] = in_valid[i];
    end
  end

  arbitration_logic_rr #(
    .N   (N),
    .IDW (IDW)
  ) u_rr (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (rr_grant)
  );

  assign load_en = !out_valid || out_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state: lock on a non-last beat, release on the last one.
  always_comb begin
    state_nx = state;
    unique case (state)
      ARB_IDLE: begin
        if (xfer && (LOCK != 0) && !sel_last) begin
          state_nx = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (xfer && sel_last) begin
          state_nx = ARB_IDLE;
        end
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

  // Grant output: round-robin pick when idle, owner only when locked.
  always_comb begin
    grant = '0;
    unique case (state)
      ARB_IDLE:   grant = rr_grant;
      ARB_LOCKED: grant[lock_id] = 1'b1;
      default:    grant = '0;
    endcase
  end

  // Ready fan-out and mux of the granted requester's beat.
  always_comb begin
    sel      = '0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = !rst && load_en && grant[i];
      if (grant[i]) begin
        sel      = IDW'(i);
        sel_data = in_data[i];
        sel_last = in_last[i];
      end
    end
    xfer   = !rst && load_en && |(grant & req);
    ptr_nx = (sel == IDW'(N - 1)) ? '0 : sel + IDW'(1);
  end

  // Pointer advances past the winner once its packet ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr  <= '0;
      lock_id <= '0;
    end else if (xfer) begin
      if (sel_last || (LOCK == 0)) begin
        rr_ptr <= ptr_nx;
      end
      if (state == ARB_IDLE) begin
        lock_id <= sel;
      end
    end
  end

  // Output register: refill whenever empty or being drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (load_en) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= sel_data;
        out_last <= sel_last;
        out_src  <= sel;
      end
    end
  end

endmodule

// File: tb/tb_arbiter_rr_locked.sv
// Scoreboard bench for the locked round-robin arbiter.
// Two instances: N=4 locking, and N=2 beat-interleaving.
module tb_arbiter_rr_locked;

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         src;
  } beat_t;

  typedef struct {
    bit full;
    bit locked;
    int owner;
    int ptr;
  } mst_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       v0 [3:0];
  logic [7:0] d0 [3:0];
  logic       l0 [3:0];
  logic       r0 [3:0];
  logic       ov0, ol0, ordy0;
  logic [7:0] od0;
  logic [1:0] os0;

  logic       v1 [1:0];
  logic [7:0] d1 [1:0];
  logic       l1 [1:0];
  logic       r1 [1:0];
  logic       ov1, ol1, ordy1;
  logic [7:0] od1;
  logic [0:0] os1;

  arbiter_rr_locked #(.DWIDTH(8), .N(4), .LOCK(1)) u0 (
    .clk(clk), .rst(rst),
    .in_valid(v0), .in_data(d0), .in_last(l0), .in_ready(r0),
    .out_valid(ov0), .out_data(od0), .out_last(ol0),
    .out_src(os0), .out_ready(ordy0)
  );

  arbiter_rr_locked #(.DWIDTH(8), .N(2), .LOCK(0)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(v1), .in_data(d1), .in_last(l1), .in_ready(r1),
    .out_valid(ov1), .out_data(od1), .out_last(ol1),
    .out_src(os1), .out_ready(ordy1)
  );

  int errors = 0;
  int checks = 0;
  beat_t q0[$];
  beat_t q1[$];
  mst_t m0, m1;
  bit acc0 [4];
  bit acc1 [4];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: rules of the arbiter in plain terms.
  function automatic void step(
    input int n, input bit lk,
    input bit v [4], input bit l [4], input bit ordy,
    inout mst_t s,
    output bit rdy [4], output bit xfer, output int g
  );
    bit load;
    load = !s.full || ordy;
    g = -1;
    if (s.locked) begin
      g = s.owner;
    end else begin
      for (int k = 0; k < n; k++) begin
        if (g < 0 && v[(s.ptr + k) % n]) g = (s.ptr + k) % n;
      end
    end
    for (int k = 0; k < 4; k++) rdy[k] = 1'b0;
    if (load && g >= 0) rdy[g] = 1'b1;
    xfer = load && g >= 0 && v[g];
    if (load) s.full = xfer;
    if (xfer) begin
      if (lk && !l[g]) begin
        s.locked = 1'b1;
        s.owner  = g;
      end else begin
        s.locked = 1'b0;
        s.ptr    = (g + 1) % n;
      end
    end
  endfunction

  // Model: checks ready/valid each cycle and queues expected beats.
  always @(negedge clk) begin
    bit v [4];
    bit l [4];
    bit rdy [4];
    bit x;
    int g;
    if (rst) begin
      m0 = '{default: 0};
      m1 = '{default: 0};
      q0.delete();
      q1.delete();
      for (int k = 0; k < 4; k++) begin
        acc0[k] = 1'b0;
        acc1[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        v[k] = v0[k];
        l[k] = l0[k];
      end
      chk("out_valid0", ov0, m0.full);
      step(4, 1'b1, v, l, ordy0, m0, rdy, x, g);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("in_ready0[%0d]", k), r0[k], rdy[k]);
        acc0[k] = v[k] && rdy[k];
      end
      if (x) q0.push_back('{d0[g], l0[g], g});

      for (int k = 0; k < 4; k++) begin
        v[k] = (k < 2) ? v1[k] : 1'b0;
        l[k] = (k < 2) ? l1[k] : 1'b0;
      end
      chk("out_valid1", ov1, m1.full);
      step(2, 1'b0, v, l, ordy1, m1, rdy, x, g);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("in_ready1[%0d]", k), r1[k], rdy[k]);
        acc1[k] = v[k] && rdy[k];
      end
      if (x) q1.push_back('{d1[g], l1[g], g});
    end
  end

  // Monitor: each consumed output beat must match the queue head.
  always @(negedge clk) begin
    beat_t b;
    if (!rst) begin
      if (ov0 && ordy0) begin
        if (q0.size() == 0) begin
          chk("q0_underflow", 1, 0);
        end else begin
          b = q0.pop_front();
          chk("out_data0", od0, b.d);
          chk("out_last0", ol0, b.l);
          chk("out_src0", os0, b.src);
        end
      end
      if (ov1 && ordy1) begin
        if (q1.size() == 0) begin
          chk("q1_underflow", 1, 0);
        end else begin
          b = q1.pop_front();
          chk("out_data1", od1, b.d);
          chk("out_last1", ol1, b.l);
          chk("out_src1", os1, b.src);
        end
      end
    end
  end

  // Random requesters: a beat is held until accepted.
  task automatic run(input int cyc, input int vp, input int lp, input int rp);
    for (int c = 0; c < cyc; c++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
        if (!v0[k] || acc0[k]) begin
          v0[k] = ($urandom_range(99) < vp);
          d0[k] = 8'($urandom);
          l0[k] = ($urandom_range(99) < lp);
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (!v1[k] || acc1[k]) begin
          v1[k] = ($urandom_range(99) < vp);
          d1[k] = 8'($urandom);
          l1[k] = ($urandom_range(99) < lp);
        end
      end
      ordy0 = ($urandom_range(99) < rp);
      ordy1 = ($urandom_range(99) < rp);
    end
  endtask

  task automatic clear_inputs(input logic val);
    for (int k = 0; k < 4; k++) begin
      v0[k] = val;
      d0[k] = 8'(k + 8'h10);
      l0[k] = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      v1[k] = val;
      d1[k] = 8'(k + 8'h20);
      l1[k] = 1'b1;
    end
  endtask

  initial begin
    ordy0 = 1'b1;
    ordy1 = 1'b1;
    clear_inputs(1'b1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid0", ov0, 0);
    chk("rst_out_valid1", ov1, 0);
    for (int k = 0; k < 4; k++) chk($sformatf("rst_in_ready0[%0d]", k), r0[k], 0);
    for (int k = 0; k < 2; k++) chk($sformatf("rst_in_ready1[%0d]", k), r1[k], 0);
    rst = 1'b0;

    run(12, 100, 100, 100);
    run(300, 70, 30, 80);
    run(150, 80, 40, 25);
    run(150, 30, 40, 100);

    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid0", ov0, 0);
    chk("async_rst_out_valid1", ov1, 0);
    clear_inputs(1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run(300, 80, 30, 70);

    clear_inputs(1'b0);
    ordy0 = 1'b1;
    ordy1 = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
